rgb_breathe_sequencer: RTL and testbench
========================================

// Module: rgb_breathe_sequencer
// PURPOSE
//   Sequences three ONION_BREATHE channels (red/green/blue) through a fixed colour pattern,
//   switching colours only on breathe-cycle boundaries so that no channel is cut off mid-breath.
//   Supplies each channel's hold-off reset and the shared per-step period.
//   Sits between the FB clock/reset macro outputs and the three breathe instances in top-level LED designs.
// PARAMETERS
//   PWM_RES_BITS      8        breathe PWM resolution; steps per breath = 1<<(PWM_RES_BITS+1)
//   PERIOD_W          24       width of period_i / breathe_period
//   CYCLES_PER_STEP   24'hAAAA breathe_period reset value (clock cycles per brightness step)
//   BREATHS_PER_COLOR 2        full breaths per colour before advancing (>=1)
// PORTS
//   Sys_Clk0        in   1         clock
//   Sys_Clk0_Rst    in   1         synchronous reset, active-high
//   enable          in   1         1 = run sequence; 0 = return to IDLE, all LEDs dark
//   pause           in   1         1 = freeze counters and hold all channels dark
//   period_i        in   PERIOD_W  requested clock cycles per step; sampled only at load points
//   breathe_period  out  PERIOD_W  period driven to all breathe instances
//   chan_off        out  3         per-channel breathe reset: [2]=blue [1]=green [0]=red; 1 = dark
//   color_idx       out  3         current pattern index, 0..5
//   step_tick       out  1         1-cycle pulse on the last cycle of each brightness step
//   breath_done     out  1         1-cycle pulse on the last cycle of each full breath
// BEHAVIOUR
//   Reset: state=IDLE, chan_off=3'b111, breathe_period=CYCLES_PER_STEP, color_idx=0,
//     step_tick=0, breath_done=0, all counters 0. All outputs are registered.
//   Pattern (lit mask {b,g,r}) for idx 0..5: 100,010,001,011,101,110; idx wraps 5->0.
//   In RUN, chan_off = ~lit_mask(color_idx).
//   Counters: cyc_cnt (PERIOD_W bits) counts 0..P-1, where P = latched period.
//     lvl_cnt (PWM_RES_BITS+1 bits) increments when cyc_cnt==P-1 and wraps at all-ones.
//     brth_cnt counts 0..BREATHS_PER_COLOR-1.
//   step_tick is asserted in the cycle after cyc_cnt==P-1 in RUN.
//   breath_done is asserted in the cycle after the step end where lvl_cnt is all-ones.
//   Load points: IDLE->RUN and every ADVANCE.
//     At a load point, breathe_period <= (period_i==0 ? 1 : period_i).
//     Between load points, period_i is ignored.
//   FSM:
//     IDLE:    chan_off=111, counters held 0. If enable && !pause -> RUN.
//              On that transition: color_idx=0, load period; chan_off takes the idx-0 mask on the next edge.
//     RUN:     count. !enable -> IDLE. Else pause -> PAUSE (no count that cycle).
//              Else, on breath end with brth_cnt==BREATHS_PER_COLOR-1 -> ADVANCE.
//     PAUSE:   chan_off=111, counters frozen. !enable -> IDLE. !pause -> RUN, resuming from the frozen counts.
//     ADVANCE: exactly 1 cycle. chan_off=111 so that every breathe instance restarts at phase 0.
//              color_idx++ (wrapping), counters cleared, period loaded. Then -> RUN (or IDLE if !enable).
//   Priority within a cycle: Sys_Clk0_Rst > !enable > pause > breath/colour advance.
//     A breath end coinciding with pause is discarded. Counters stay at their last value, and the end fires after resume.
//   Reset mid-sequence returns to the reset values on the next edge, irrespective of state.
//   Count arithmetic is unsigned. cyc_cnt compare uses the latched P, never period_i.
// TESTING (bench params: PWM_RES_BITS=2 -> 8 steps/breath, BREATHS_PER_COLOR=2)
//   1. Reset, enable=1, period_i=3 -> breathe_period=3, chan_off=011 (blue lit).
//      step_tick every 3 cycles; breath_done every 24 cycles.
//   2. Continue from 1 -> after 48 RUN cycles, one cycle chan_off=111, then color_idx=1, chan_off=101.
//      Six colours later, color_idx wraps to 0.
//   3. Change period_i to 5 mid-colour -> breathe_period stays 3 until the next ADVANCE, then becomes 5.
//      period_i=0 at a load point -> 1.
//   4. pause=1 for 10 cycles mid-step -> chan_off=111, counters frozen.
//      After release, the remaining step length is unchanged; pause on a breath-end cycle delays breath_done until resume.
//   5. enable=0 during PAUSE or ADVANCE -> IDLE next cycle, chan_off=111, color_idx=0 on re-enable.
//   6. Assert Sys_Clk0_Rst for 1 cycle mid-RUN -> all outputs at reset values on the next edge.
//      With enable still 1, RUN restarts at idx 0.

Source files
------------

// File: rtl/rgb_breathe_sequencer_if.sv
// Control/status bundle between the LED top level and the RGB breathe sequencer.
// The master side drives the run controls; the slave side returns period and channel state.
interface rgb_breathe_sequencer_if #(
  parameter int unsigned PERIOD_W = 24
);
  logic                enable;
  logic                pause;
  logic [PERIOD_W-1:0] period_i;
  logic [PERIOD_W-1:0] breathe_period;
  logic [2:0]          chan_off;
  logic [2:0]          color_idx;
  logic                step_tick;
  logic                breath_done;

  modport master (
    output enable, pause, period_i,
    input  breathe_period, chan_off, color_idx, step_tick, breath_done
  );

  modport slave (
    input  enable, pause, period_i,
    output breathe_period, chan_off, color_idx, step_tick, breath_done
  );
endinterface

// File: rtl/rgb_breathe_sequencer.sv
// Steps three breathe channels through a six-colour pattern, changing colour only
// on breath boundaries and holding every channel dark for one cycle at each change.
module rgb_breathe_sequencer #(
  parameter int unsigned PWM_RES_BITS      = 8,
  parameter int unsigned PERIOD_W          = 24,
  parameter logic [PERIOD_W-1:0] CYCLES_PER_STEP = 24'hAAAA,
  parameter int unsigned BREATHS_PER_COLOR = 2
) (
  input  logic                     Sys_Clk0,
  input  logic                     Sys_Clk0_Rst,
  rgb_breathe_sequencer_if.slave   bus
);

  localparam int unsigned LVL_W  = PWM_RES_BITS + 1;
  localparam int unsigned BRTH_W = (BREATHS_PER_COLOR > 1) ? $clog2(BREATHS_PER_COLOR) : 1;
  localparam logic [BRTH_W-1:0] BRTH_LAST = BRTH_W'(BREATHS_PER_COLOR - 1);
  localparam logic [2:0] IDX_LAST = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ADV} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cyc_q, cyc_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [BRTH_W-1:0]   brth_q, brth_d;
  logic [2:0]          color_q, color_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [2:0]          chan_off_q, chan_off_d;
  logic                step_tick_q, step_tick_d;
  logic                breath_done_q, breath_done_d;

  logic                step_end, breath_end, last_brth, run_cnt;
  logic [PERIOD_W-1:0] load_val;

  // Lit mask {b,g,r} for each pattern index.
  function automatic logic [2:0] lit_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    lit_mask = 3'b100;
      3'd1:    lit_mask = 3'b010;
      3'd2:    lit_mask = 3'b001;
      3'd3:    lit_mask = 3'b011;
      3'd4:    lit_mask = 3'b101;
      3'd5:    lit_mask = 3'b110;
      default: lit_mask = 3'b000;
    endcase
  endfunction

  assign step_end   = (cyc_q == (period_q - PERIOD_W'(1)));
  assign breath_end = step_end && (lvl_q == '1);
  assign last_brth  = (brth_q == BRTH_LAST);
  assign run_cnt    = (state_q == S_RUN) && bus.enable && !bus.pause;
  assign load_val   = (bus.period_i == '0) ? PERIOD_W'(1) : bus.period_i;

  always_ff @(posedge Sys_Clk0) begin
    if (Sys_Clk0_Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.enable && !bus.pause) state_d = S_RUN;
      S_RUN: begin
        if (!bus.enable)                  state_d = S_IDLE;
        else if (bus.pause)               state_d = S_PAUSE;
        else if (breath_end && last_brth) state_d = S_ADV;
      end
      S_PAUSE: begin
        if (!bus.enable)     state_d = S_IDLE;
        else if (!bus.pause) state_d = S_RUN;
      end
      S_ADV:   state_d = bus.enable ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, colour, period and registered-output next values.
  always_comb begin
    cyc_d         = cyc_q;
    lvl_d         = lvl_q;
    brth_d        = brth_q;
    color_d       = color_q;
    period_d      = period_q;
    step_tick_d   = 1'b0;
    breath_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cyc_d   = '0;
        lvl_d   = '0;
        brth_d  = '0;
        color_d = 3'd0;
        if (state_d == S_RUN) period_d = load_val;
      end
      S_RUN: begin
        if (run_cnt) begin
          if (step_end) begin
            cyc_d       = '0;
            lvl_d       = lvl_q + LVL_W'(1);
            step_tick_d = 1'b1;
            if (breath_end) begin
              breath_done_d = 1'b1;
              brth_d        = last_brth ? '0 : brth_q + BRTH_W'(1);
            end
          end else begin
            cyc_d = cyc_q + PERIOD_W'(1);
          end
        end
      end
      S_ADV: begin
        cyc_d    = '0;
        lvl_d    = '0;
        brth_d   = '0;
        color_d  = (color_q == IDX_LAST) ? 3'd0 : color_q + 3'd1;
        period_d = load_val;
      end
      default: ;
    endcase

    // Leaving the sequence always restarts it from the first colour.
    if (state_d == S_IDLE) begin
      cyc_d   = '0;
      lvl_d   = '0;
      brth_d  = '0;
      color_d = 3'd0;
    end

    chan_off_d = (state_d == S_RUN) ? ~lit_mask(color_d) : 3'b111;
  end

  always_ff @(posedge Sys_Clk0) begin
    if (Sys_Clk0_Rst) begin
      cyc_q         <= '0;
      lvl_q         <= '0;
      brth_q        <= '0;
      color_q       <= 3'd0;
      period_q      <= CYCLES_PER_STEP;
      chan_off_q    <= 3'b111;
      step_tick_q   <= 1'b0;
      breath_done_q <= 1'b0;
    end else begin
      cyc_q         <= cyc_d;
      lvl_q         <= lvl_d;
      brth_q        <= brth_d;
      color_q       <= color_d;
      period_q      <= period_d;
      chan_off_q    <= chan_off_d;
      step_tick_q   <= step_tick_d;
      breath_done_q <= breath_done_d;
    end
  end

  assign bus.breathe_period = period_q;
  assign bus.chan_off       = chan_off_q;
  assign bus.color_idx      = color_q;
  assign bus.step_tick      = step_tick_q;
  assign bus.breath_done    = breath_done_q;

endmodule

// File: tb/tb_rgb_breathe_sequencer.sv
// Directed bench for rgb_breathe_sequencer with 8 steps per breath and 2 breaths per colour.
module tb_rgb_breathe_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  rgb_breathe_sequencer_if #(.PERIOD_W(24)) bus ();

  rgb_breathe_sequencer #(
    .PWM_RES_BITS     (2),
    .PERIOD_W         (24),
    .CYCLES_PER_STEP  (24'hAAAA),
    .BREATHS_PER_COLOR(2)
  ) dut (
    .Sys_Clk0    (clk),
    .Sys_Clk0_Rst(rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after a load edge; leaves just after the edge into the one-cycle ADVANCE.
  task automatic check_color(input int p, input logic [2:0] off, input logic [2:0] idx,
                             input int chg_t, input int chg_p);
    chk("load_chan_off", 32'(bus.chan_off), 32'(off));
    chk("load_color_idx", 32'(bus.color_idx), 32'(idx));
    chk("load_period", 32'(bus.breathe_period), 32'(p));
    chk("load_step_tick", 32'(bus.step_tick), 32'd0);
    for (int t = 1; t <= 16 * p; t++) begin
      tick();
      chk("step_tick", 32'(bus.step_tick), 32'((t % p) == 0));
      chk("breath_done", 32'(bus.breath_done), 32'((t % (8 * p)) == 0));
      chk("chan_off", 32'(bus.chan_off), (t == 16 * p) ? 32'd7 : 32'(off));
      chk("period_hold", 32'(bus.breathe_period), 32'(p));
      chk("color_hold", 32'(bus.color_idx), 32'(idx));
      if (t == chg_t) bus.period_i = 24'(chg_p);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.enable   = 1'b0;
    bus.pause    = 1'b0;
    bus.period_i = 24'd3;
    repeat (2) tick();
    chk("rst_chan_off", 32'(bus.chan_off), 32'd7);
    chk("rst_period", 32'(bus.breathe_period), 32'hAAAA);
    chk("rst_color", 32'(bus.color_idx), 32'd0);
    chk("rst_step_tick", 32'(bus.step_tick), 32'd0);
    chk("rst_breath_done", 32'(bus.breath_done), 32'd0);

    // Full pattern walk; period_i changes mid-colour take effect only at ADVANCE.
    rst        = 1'b0;
    bus.enable = 1'b1;
    tick();
    check_color(3, 3'b011, 3'd0, 5, 5);
    tick();
    check_color(5, 3'b101, 3'd1, 7, 0);
    tick();
    check_color(1, 3'b110, 3'd2, -1, 0);
    tick();
    check_color(1, 3'b100, 3'd3, -1, 0);
    tick();
    check_color(1, 3'b010, 3'd4, -1, 0);
    tick();
    check_color(1, 3'b001, 3'd5, 2, 3);
    tick();
    chk("wrap_color", 32'(bus.color_idx), 32'd0);
    chk("wrap_chan_off", 32'(bus.chan_off), 32'(3'b011));
    chk("wrap_period", 32'(bus.breathe_period), 32'd3);

    // Pause mid-step: frozen and dark, then the remaining two RUN cycles of the step.
    tick();
    chk("pre_pause_tick", 32'(bus.step_tick), 32'd0);
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_chan_off", 32'(bus.chan_off), 32'd7);
      chk("pause_step_tick", 32'(bus.step_tick), 32'd0);
    end
    bus.pause = 1'b0;
    tick();
    chk("resume_chan_off", 32'(bus.chan_off), 32'(3'b011));
    chk("resume_tick0", 32'(bus.step_tick), 32'd0);
    tick();
    chk("resume_tick1", 32'(bus.step_tick), 32'd0);
    tick();
    chk("resume_tick2", 32'(bus.step_tick), 32'd1);

    // Pause on the breath-end cycle defers breath_done until after resume.
    repeat (20) tick();
    chk("pre_bend_done", 32'(bus.breath_done), 32'd0);
    bus.pause = 1'b1;
    tick();
    chk("bend_pause_done", 32'(bus.breath_done), 32'd0);
    chk("bend_pause_off", 32'(bus.chan_off), 32'd7);
    repeat (3) tick();
    bus.pause = 1'b0;
    tick();
    chk("bend_resume_done", 32'(bus.breath_done), 32'd0);
    tick();
    chk("bend_late_done", 32'(bus.breath_done), 32'd1);
    chk("bend_late_tick", 32'(bus.step_tick), 32'd1);

    // Second breath completes, then enable drops during ADVANCE.
    repeat (24) tick();
    chk("adv_chan_off", 32'(bus.chan_off), 32'd7);
    chk("adv_breath_done", 32'(bus.breath_done), 32'd1);
    bus.enable = 1'b0;
    tick();
    chk("adv_idle_off", 32'(bus.chan_off), 32'd7);
    bus.enable = 1'b1;
    tick();
    chk("reen1_color", 32'(bus.color_idx), 32'd0);
    chk("reen1_chan_off", 32'(bus.chan_off), 32'(3'b011));
    chk("reen1_period", 32'(bus.breathe_period), 32'd3);

    // Reach colour 1, then drop enable while paused.
    repeat (48) tick();
    tick();
    chk("c1_color", 32'(bus.color_idx), 32'd1);
    chk("c1_chan_off", 32'(bus.chan_off), 32'(3'b101));
    bus.pause = 1'b1;
    tick();
    chk("c1_pause_off", 32'(bus.chan_off), 32'd7);
    bus.enable = 1'b0;
    bus.pause  = 1'b0;
    tick();
    chk("pause_idle_off", 32'(bus.chan_off), 32'd7);
    bus.enable = 1'b1;
    tick();
    chk("reen2_color", 32'(bus.color_idx), 32'd0);
    chk("reen2_chan_off", 32'(bus.chan_off), 32'(3'b011));

    // Synchronous reset mid-RUN, landing on a step_tick pulse.
    repeat (3) tick();
    chk("pre_rst_tick", 32'(bus.step_tick), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_chan_off", 32'(bus.chan_off), 32'd7);
    chk("mid_rst_period", 32'(bus.breathe_period), 32'hAAAA);
    chk("mid_rst_color", 32'(bus.color_idx), 32'd0);
    chk("mid_rst_tick", 32'(bus.step_tick), 32'd0);
    chk("mid_rst_done", 32'(bus.breath_done), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_chan_off", 32'(bus.chan_off), 32'(3'b011));
    chk("post_rst_color", 32'(bus.color_idx), 32'd0);
    chk("post_rst_period", 32'(bus.breathe_period), 32'd3);
    repeat (2) tick();
    chk("post_rst_tick_early", 32'(bus.step_tick), 32'd0);
    tick();
    chk("post_rst_tick", 32'(bus.step_tick), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
